// File: rtl/dsp48a1_pkg.sv
// Shared DSP48A1 definitions: OPMODE field encodings and the sequencer state enum.
package dsp48a1_pkg;

  localparam logic [1:0] OPM_X_M    = 2'b01;
  localparam logic [1:0] OPM_Z_ZERO = 2'b00;
  localparam logic [1:0] OPM_Z_P    = 2'b10;

  // Pre-adder, carry-in and post-subtract bits stay 0 for a plain MAC.
  localparam logic [7:0] OPM_MAC_FIRST = {4'b0000, OPM_Z_ZERO, OPM_X_M};
  localparam logic [7:0] OPM_MAC_ACC   = {4'b0000, OPM_Z_P,    OPM_X_M};

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } state_t;

  function automatic logic [7:0] mac_opmode(input logic first);
    return first ? OPM_MAC_FIRST : OPM_MAC_ACC;
  endfunction

endpackage

// File: rtl/dsp_pipe_tracker.sv
// Valid/first shift registers mirroring the slice pipeline; drives per-stage
// clock enables and counts P-stage enables issued for the current job.
module dsp_pipe_tracker #(
  parameter int PIPE_LATENCY = 3,
  parameter int LEN_WIDTH    = 8
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    push,
  input  logic                    push_first,
  output logic [PIPE_LATENCY-1:0] ce,
  output logic                    first_p,
  output logic [LEN_WIDTH-1:0]    ce_p_count
);

  logic [PIPE_LATENCY-1:0] vsr;
  logic [PIPE_LATENCY-1:0] fsr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, exactly like the hardware flops it models.
  always_ff @(posedge CLK) begin
    if (rst) begin
      vsr        <= '0;
      fsr        <= '0;
      ce_p_count <= '0;
    end else begin
      vsr <= {vsr[PIPE_LATENCY-2:0], push};
      fsr <= {fsr[PIPE_LATENCY-2:0], push & push_first};
      if (clear)
        ce_p_count <= '0;
      else if (vsr[PIPE_LATENCY-1])
        ce_p_count <= ce_p_count + 1'b1;
    end
  end

  assign ce      = vsr;
  assign first_p = fsr[PIPE_LATENCY-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Streams operand pairs into a DSP48A1 slice and collects the dot product;
// stalls become pipeline bubbles via per-stage clock enables.
module dsp_mac_sequencer
  import dsp48a1_pkg::*;
#(
  parameter int DATAWIDTH    = 18,
  parameter int LEN_WIDTH    = 8,
  parameter int PIPE_LATENCY = 3,
  parameter int RESULTWIDTH  = 48
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    len,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATAWIDTH-1:0]    a_in,
  input  logic [DATAWIDTH-1:0]    b_in,
  output logic [DATAWIDTH-1:0]    dsp_a,
  output logic [DATAWIDTH-1:0]    dsp_b,
  output logic [7:0]              dsp_opmode,
  output logic [PIPE_LATENCY-1:0] dsp_ce,
  input  logic [RESULTWIDTH-1:0]  dsp_p,
  output logic                    res_valid,
  output logic [RESULTWIDTH-1:0]  res_data
);

  state_t                  state, state_nxt;
  logic [LEN_WIDTH-1:0]    remaining;
  logic [LEN_WIDTH-1:0]    job_len;
  logic [LEN_WIDTH-1:0]    ce_p_count;
  logic [PIPE_LATENCY-1:0] ce;
  logic                    first_p;
  logic                    accept;
  logic                    job_start;

  always_ff @(posedge CLK) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    in_ready  = 1'b0;
    res_valid = 1'b0;
    accept    = 1'b0;
    job_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          job_start = 1'b1;
          state_nxt = (len != '0) ? FEED : DONE;
        end
      end
      FEED: begin
        in_ready = (remaining != '0);
        accept   = in_valid && in_ready;
        if (accept && remaining == LEN_WIDTH'(1))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (ce_p_count == job_len)
          state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      remaining <= '0;
      job_len   <= '0;
      dsp_a     <= '0;
      dsp_b     <= '0;
      res_data  <= '0;
    end else begin
      if (job_start) begin
        job_len   <= len;
        remaining <= len;
        if (len == '0)
          res_data <= '0;
      end
      if (accept) begin
        dsp_a     <= a_in;
        dsp_b     <= b_in;
        remaining <= remaining - 1'b1;
      end
      // P was written by the last enable one cycle earlier, so it is settled here.
      if (state == DRAIN && state_nxt == DONE)
        res_data <= dsp_p;
    end
  end

  dsp_pipe_tracker #(
    .PIPE_LATENCY (PIPE_LATENCY),
    .LEN_WIDTH    (LEN_WIDTH)
  ) u_tracker (
    .CLK        (CLK),
    .rst        (rst),
    .clear      (job_start),
    .push       (accept),
    .push_first (remaining == job_len),
    .ce         (ce),
    .first_p    (first_p),
    .ce_p_count (ce_p_count)
  );

  assign dsp_ce     = ce;
  assign dsp_opmode = (state == IDLE) ? 8'h00 : mac_opmode(first_p);

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural A/B-M-P slice model and a
// result scoreboard checked against expected value and arrival cycle.
module tb_dsp_mac_sequencer;

  localparam int DW = 18;
  localparam int LW = 8;
  localparam int PL = 3;
  localparam int RW = 48;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] a_in = '0;
  logic [DW-1:0] b_in = '0;
  logic          busy, in_ready, res_valid;
  logic [DW-1:0] dsp_a, dsp_b;
  logic [7:0]    dsp_opmode;
  logic [PL-1:0] dsp_ce;
  logic [RW-1:0] dsp_p, res_data;

  always #5 CLK = ~CLK;

  dsp_mac_sequencer #(
    .DATAWIDTH(DW), .LEN_WIDTH(LW), .PIPE_LATENCY(PL), .RESULTWIDTH(RW)
  ) dut (
    .CLK(CLK), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce),
    .dsp_p(dsp_p), .res_valid(res_valid), .res_data(res_data)
  );

  // Slice model: AB, M and P registers, each on its own enable; never reset.
  logic signed [DW-1:0]   a_r = '0, b_r = '0;
  logic signed [2*DW-1:0] m_r = '0;
  logic signed [RW-1:0]   p_r = '0;
  logic signed [RW-1:0]   m_ext;
  assign m_ext = {{(RW-2*DW){m_r[2*DW-1]}}, m_r};

  always @(posedge CLK) begin
    if (dsp_ce[0] === 1'b1) begin
      a_r <= dsp_a;
      b_r <= dsp_b;
    end
    if (dsp_ce[1] === 1'b1) m_r <= a_r * b_r;
    if (dsp_ce[2] === 1'b1)
      p_r <= ((dsp_opmode[3:2] == 2'b10) ? p_r : '0) +
             ((dsp_opmode[1:0] == 2'b01) ? m_ext : '0);
  end
  assign dsp_p = p_r;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [RW-1:0] data;
    int            at;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] pa[8];
  logic [DW-1:0] pb[8];
  logic [PL-1:0] ce_hist  [0:4095];
  logic [7:0]    opm_hist [0:4095];

  always @(negedge CLK) begin
    exp_t e;
    ce_hist[cyc[11:0]]  = dsp_ce;
    opm_hist[cyc[11:0]] = dsp_opmode;
    if (res_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got pulse with %0d at cycle %0d, required no pulse",
                 $signed(res_data), cyc);
      end else begin
        e = sb.pop_front();
        if (res_data !== e.data) begin
          errors++;
          $display("FAIL res_data: got %0d, required %0d", $signed(res_data), $signed(e.data));
        end
        checks++;
        if (cyc != e.at) begin
          errors++;
          $display("FAIL res_latency: got cycle %0d, required cycle %0d", cyc, e.at);
        end
      end
    end
  end

  // Launches a job at the next falling edge; f is the cycle in which the
  // first accepted pair appears on the AB-stage enable.
  task automatic start_job(input int n, input bit gaps, input logic [RW-1:0] expv,
                           output int f);
    int c;
    @(negedge CLK);
    c     = cyc;
    start = 1'b1;
    len   = LW'(n);
    sb.push_back('{expv, (n == 0) ? c + 1 : c + 2 + n + PL + (gaps ? n - 1 : 0)});
    f = c + 2;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      a_in     = pa[i];
      b_in     = pb[i];
      in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL in_ready pair %0d: got %b, required 1", i, in_ready);
      end
      @(negedge CLK);
      if (gaps && i < n - 1) begin
        in_valid = 1'b0;
        @(negedge CLK);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit spam, input string name);
    int t = 0;
    while (busy === 1'b1 && t < 200) begin
      if (spam) begin
        start = 1'b1;
        len   = 8'd3;
      end
      @(negedge CLK);
      t++;
    end
    start = 1'b0;
    len   = '0;
    checks++;
    if (t >= 200) begin
      errors++;
      $display("FAIL %s timeout: busy still %b after %0d cycles, required 0", name, busy, t);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s missing_result: %0d pending, required 0", name, sb.size());
      sb.delete();
    end
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after_done: busy %b, required 0", name, busy);
    end
  endtask

  task automatic check_ce(input int f, input int n, input bit gaps, input string name);
    int last = f + (gaps ? 2 * n : n) + PL + 1;
    int bad_op = 0;
    for (int k = 0; k < PL; k++) begin
      int bad = 0;
      for (int t = f - 1; t <= last; t++) begin
        int   d = t - f - k;
        logic want = gaps ? (d >= 0 && d % 2 == 0 && d / 2 < n) : (d >= 0 && d < n);
        if (ce_hist[t[11:0]][k] !== want) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s dsp_ce[%0d]: %0d wrong cycles, required 0", name, k, bad);
      end
    end
    for (int t = f - 1; t <= last; t++) begin
      if (ce_hist[t[11:0]][PL-1] === 1'b1 &&
          opm_hist[t[11:0]] !== ((t == f + PL - 1) ? 8'h01 : 8'h09)) bad_op++;
    end
    checks++;
    if (bad_op != 0) begin
      errors++;
      $display("FAIL %s dsp_opmode: %0d wrong ce_p cycles, required 0", name, bad_op);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({busy, in_ready, res_valid} !== 3'b000) begin
      errors++;
      $display("FAIL %s ctrl: busy/in_ready/res_valid %b, required 000", name,
               {busy, in_ready, res_valid});
    end
    checks++;
    if ({dsp_ce, dsp_opmode} !== '0) begin
      errors++;
      $display("FAIL %s dsp_ctrl: ce %b opmode %h, required 0/00", name, dsp_ce, dsp_opmode);
    end
    checks++;
    if ({dsp_a, dsp_b, res_data} !== '0) begin
      errors++;
      $display("FAIL %s data: a %h b %h res %h, required 0", name, dsp_a, dsp_b, res_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_gapless();
    int f;
    pa[0] = 18'd1; pb[0] = 18'd2;
    pa[1] = 18'd3; pb[1] = 18'd4;
    pa[2] = 18'd5; pb[2] = 18'd6;
    pa[3] = 18'd7; pb[3] = 18'd8;
    start_job(4, 1'b0, 48'd100, f);
    wait_done(1'b0, "gapless");
    check_ce(f, 4, 1'b0, "gapless");
  endtask

  task automatic test_bubbles();
    int f;
    start_job(4, 1'b1, 48'd100, f);
    wait_done(1'b0, "bubbles");
    check_ce(f, 4, 1'b1, "bubbles");
  endtask

  task automatic test_signed();
    int            f;
    logic [RW-1:0] expv;
    expv  = -131086;
    pa[0] = DW'(-3);     pb[0] = 18'd5;
    pa[1] = 18'd131071;  pb[1] = DW'(-1);
    start_job(2, 1'b0, expv, f);
    wait_done(1'b0, "signed");
    check_ce(f, 2, 1'b0, "signed");
  endtask

  task automatic test_zero_len();
    int f;
    start_job(0, 1'b0, 48'd0, f);
    wait_done(1'b0, "zero_len");
    repeat (4) @(negedge CLK);
    check_ce(f, 0, 1'b0, "zero_len");
  endtask

  task automatic test_abort();
    int f;
    for (int i = 0; i < 5; i++) begin
      pa[i] = DW'(i + 1);
      pb[i] = DW'(i + 2);
    end
    @(negedge CLK);
    start = 1'b1;
    len   = 8'd5;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_in = pa[i]; b_in = pb[i]; in_valid = 1'b1;
      @(negedge CLK);
    end
    a_in = pa[2]; b_in = pb[2];
    rst  = 1'b1;
    @(negedge CLK);
    check_all_zero("abort");
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (8) @(negedge CLK);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort idle: busy %b, required 0", busy);
    end
    pa[0] = 18'd4; pb[0] = 18'd4;
    start_job(1, 1'b0, 48'd16, f);
    wait_done(1'b0, "after_abort");
    check_ce(f, 1, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    int f;
    pa[0] = 18'd2; pb[0] = 18'd3;
    start_job(1, 1'b0, 48'd6, f);
    wait_done(1'b1, "b2b_job1");
    pa[0] = 18'd5; pb[0] = 18'd5;
    start_job(1, 1'b0, 48'd25, f);
    wait_done(1'b1, "b2b_job2");
    check_ce(f, 1, 1'b0, "b2b_job2");
  endtask

  initial begin
    test_reset();
    test_gapless();
    test_bubbles();
    test_signed();
    test_zero_len();
    test_abort();
    test_back_to_back();
    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Sequences one DSP48A1 slice through dot-product jobs: for a job of length N it computes sum(a_i*b_i).
- Streams operand pairs into the slice over a valid/ready handshake.
- Drives the slice's OPMODE and per-stage clock enables so stalls insert bubbles without corrupting the accumulator.
- Captures the final P value as a one-cycle result pulse.
- Sits between the operand-fetch logic and the DSP48A1 top, which is configured with A/B, M and P registers enabled.

Parameters:
- DATAWIDTH, 18, width of the A and B operands.
- LEN_WIDTH, 8, width of the job length field.
- PIPE_LATENCY, 3, number of enabled register stages from the slice's A/B inputs to P (AB reg, M reg, P reg); legal range 2..6.
- RESULTWIDTH, 48, width of P and of the result.

Ports:
- CLK  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_WIDTH  number of operand pairs; captured with start.
- busy  out  1  high from the start-accept edge until the result pulse.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  high only in FEED while pairs remain.
- a_in  in  DATAWIDTH  operand A.
- b_in  in  DATAWIDTH  operand B.
- dsp_a  out  DATAWIDTH  registered A to slice.
- dsp_b  out  DATAWIDTH  registered B to slice.
- dsp_opmode  out  8  slice OPMODE.
- dsp_ce  out  PIPE_LATENCY  per-stage clock enables; bit 0 = AB stage, MSB = P stage.
- dsp_p  in  RESULTWIDTH  slice P output.
- res_valid  out  1  one-cycle result pulse.
- res_data  out  RESULTWIDTH  result; held until the next pulse.

Behaviour:
- Reset values: all outputs 0, including dsp_ce, dsp_opmode, res_data, busy and in_ready. Internal state: IDLE, counters 0, valid/first shift registers 0.
- rst mid-job: abort immediately with the same reset values. No res_valid for the aborted job. Accumulator garbage is harmless because the next job's first product uses Z=0.
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - start=1 and len>0: latch len into the remaining count; go to FEED; busy=1.
  - start=1 and len=0: go to DONE with res_data forced to 0 and no DSP activity.
  - start while busy: ignored.
- FEED:
  - in_ready=1 while remaining>0.
  - On an edge with in_valid & in_ready: register a_in/b_in onto dsp_a/dsp_b, shift a 1 into the valid shift register vsr, shift first=(this is pair 0) into fsr, and decrement remaining.
  - Otherwise shift a 0 (bubble) into vsr; dsp_a/dsp_b hold their values.
  - Go to DRAIN on the edge that accepts the last pair.
- Enable alignment: dsp_ce[k] = vsr[k], so every stage clocks only its own valid data. vsr has PIPE_LATENCY bits; bit 0 is loaded at the accept edge.
- OPMODE, driven alongside the P-stage enable:
  - dsp_ce[MSB]=1 and fsr[MSB]=1: 8'h01 (X=M, Z=0), which starts the accumulation.
  - dsp_ce[MSB]=1 and fsr[MSB]=0: 8'h09 (X=M, Z=P), which accumulates.
  - Otherwise 8'h09; ignored because ce_p=0.
  - Pre-adder and post-subtract bits are always 0.
- DRAIN:
  - in_ready=0; vsr shifts in zeros.
  - Track the count of P-stage enables issued for the job.
  - When it equals len, go to DONE on the next edge.
- DONE (one cycle): res_data <= dsp_p and res_valid=1 for that cycle. The final P value is stable by then. Next state is IDLE; busy drops with res_valid.
- Latency, gapless stream: first pair accepted at edge 0, last at edge len-1; res_valid is high in cycle len+PIPE_LATENCY.
  - Each in_valid=0 bubble adds exactly one cycle.
  - The result is independent of bubble placement.
- Width rules:
  - Product and accumulation are signed two's complement, computed in the slice.
  - The sequencer does no arithmetic on data, only counting.
  - Overflow beyond RESULTWIDTH wraps, as in the slice.
- A start asserted in the DONE cycle is ignored. A new job needs start in IDLE, so job-to-job spacing is at least 1 idle cycle.

Decomposition:
- Shared package dsp48a1_pkg holds:
  - OPMODE field constants: OPM_X_M=2'b01, OPM_Z_ZERO=2'b00, OPM_Z_P=2'b10, and the derived OPM_MAC_FIRST=8'h01 and OPM_MAC_ACC=8'h09.
  - The state enum (IDLE, FEED, DRAIN, DONE).
- One sub-module: dsp_pipe_tracker, the PIPE_LATENCY-deep valid/first shift register that produces dsp_ce, the P-stage first flag, and the drained-enable count.

Test Plan:
- len=4, pairs (1,2),(3,4),(5,6),(7,8) with in_valid held high -> res_data=100, res_valid exactly in cycle 7 (len+PIPE_LATENCY), dsp_opmode=8'h01 only on the first ce_p cycle.
- Same job with in_valid low on alternating cycles -> res_data=100, result delayed by the 3 bubble cycles, and dsp_ce shows matching 0 gaps per stage.
- Signed values: len=2, pairs (-3,5),(131071,-1) -> res_data=-131086 sign-extended to 48 bits.
- len=0 -> no dsp_ce activity, res_valid with res_data=0 in the cycle after start.
- rst asserted during FEED after 2 of 5 pairs -> all outputs 0 next cycle with no res_valid; a new len=1 job (4,4) then returns 16, proving Z=0 clears the stale P.
- Back-to-back jobs plus start pulses while busy -> extra starts ignored, and each job's result is independent (jobs 2*3=6 then 5*5=25).
